// File: rtl/calc_key_if.sv
// Board-side key/switch inputs, datapath busy handshake and op strobes
// for the calculator key sequencer.
interface calc_key_if;
  logic [3:0] KEY;
  logic       mode_sw;
  logic       calc_busy;
  logic       op_clear;
  logic       op_result;
  logic       op_add;
  logic       op_sub;
  logic       op_mult;
  logic       op_div;
  logic       dropped;
  logic       timeout_err;
  logic [2:0] state_dbg;

  modport master (
    output KEY, mode_sw, calc_busy,
    input  op_clear, op_result, op_add, op_sub, op_mult, op_div,
    input  dropped, timeout_err, state_dbg
  );

  modport slave (
    input  KEY, mode_sw, calc_busy,
    output op_clear, op_result, op_add, op_sub, op_mult, op_div,
    output dropped, timeout_err, state_dbg
  );
endinterface

// File: rtl/calc_key_sequencer.sv
// Key sequencer: per-input sync/debounce lanes feeding a 4-state op issue FSM
// with a 1-deep pending slot, busy timeout and clear override.
module calc_key_debounce #(
  parameter int unsigned CYCLES  = 4,
  parameter bit          RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic fall_o
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q, fall_q;

  // Level flips only after CYCLES consecutive synced samples disagree with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= {2{RST_VAL}};
      cnt_q   <= '0;
      level_q <= RST_VAL;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
        fall_q  <= level_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;
endmodule

module calc_key_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BUSY_TIMEOUT    = 4096
) (
  input  logic      CLOCK_50,
  input  logic      RESET_N,
  calc_key_if.slave bus
);
  localparam int NUM_IN = 5;
  localparam int TW     = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE = 3'd0, ISSUE = 3'd1, ACK = 3'd2, WAIT_DONE = 3'd3} state_e;
  typedef enum logic [2:0] {OP_CLEAR, OP_RESULT, OP_ADD, OP_SUB, OP_MULT, OP_DIV} op_e;
  typedef struct packed {
    logic vld;
    op_e  op;
  } op_req_t;

  logic [NUM_IN-1:0] raw, level, fall;
  logic [3:0]        press, valid, win;
  logic              mode, lose, is_clr, unused_bits;
  op_req_t           nreq, pend_q, pend_d;
  state_e            state_q, state_d;
  op_e               cur_q, cur_d;
  logic              drop_q, drop_d, tmo_q, tmo_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;

  assign raw = {bus.mode_sw, bus.KEY};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    calc_key_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(i != NUM_IN - 1)) u_db (
      .clk_i(CLOCK_50), .rst_ni(RESET_N), .raw_i(raw[i]),
      .level_o(level[i]), .fall_o(fall[i])
    );
  end

  assign press       = fall[3:0];
  assign mode        = level[NUM_IN-1];
  assign unused_bits = ^{level[3:0], fall[NUM_IN-1]};

  // KEY1/KEY2 are masked in control mode so they neither win nor count as drops.
  always_comb begin
    valid    = mode ? (press & 4'b1001) : press;
    win      = valid & (~valid + 4'd1);
    lose     = |(valid & ~win);
    nreq.vld = |valid;
    nreq.op  = OP_ADD;
    if (mode)        nreq.op = win[0] ? OP_CLEAR : OP_RESULT;
    else if (win[0]) nreq.op = OP_DIV;
    else if (win[1]) nreq.op = OP_MULT;
    else if (win[2]) nreq.op = OP_SUB;
    is_clr = nreq.vld && (nreq.op == OP_CLEAR);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cur_q   <= OP_CLEAR;
      pend_q  <= '0;
      drop_q  <= 1'b0;
      tmo_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      tmo_q   <= tmo_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    drop_d  = drop_q | lose;
    tmo_d   = tmo_q;
    tcnt_d  = tcnt_q;

    if (state_q != IDLE && nreq.vld && !is_clr) begin
      if (!pend_q.vld) pend_d = nreq;
      else             drop_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_q.vld) begin
          state_d = ISSUE;
          cur_d   = pend_q.op;
          pend_d  = nreq;
        end else if (nreq.vld) begin
          state_d = ISSUE;
          cur_d   = nreq.op;
        end
      end
      ISSUE: begin
        state_d = ACK;
        tcnt_d  = '0;
      end
      ACK: begin
        tcnt_d  = tcnt_q + TW'(1);
        state_d = bus.calc_busy ? WAIT_DONE : IDLE;
      end
      WAIT_DONE: begin
        if (!bus.calc_busy) begin
          state_d = IDLE;
        end else if (tcnt_q == TW'(BUSY_TIMEOUT - 1)) begin
          state_d    = IDLE;
          tmo_d      = 1'b1;
          pend_d.vld = 1'b0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear pre-empts whatever is in flight and wipes the queue.
    if (is_clr) begin
      state_d = ISSUE;
      cur_d   = OP_CLEAR;
      pend_d  = '0;
    end
    if (state_q == ISSUE && cur_q == OP_CLEAR) begin
      drop_d = 1'b0;
      tmo_d  = 1'b0;
    end
  end

  assign bus.op_clear    = (state_q == ISSUE) && (cur_q == OP_CLEAR);
  assign bus.op_result   = (state_q == ISSUE) && (cur_q == OP_RESULT);
  assign bus.op_add      = (state_q == ISSUE) && (cur_q == OP_ADD);
  assign bus.op_sub      = (state_q == ISSUE) && (cur_q == OP_SUB);
  assign bus.op_mult     = (state_q == ISSUE) && (cur_q == OP_MULT);
  assign bus.op_div      = (state_q == ISSUE) && (cur_q == OP_DIV);
  assign bus.dropped     = drop_q;
  assign bus.timeout_err = tmo_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer: decode table plus hand-built busy,
// pending, drop, timeout, clear-override and reset sequences.
module tb_calc_key_sequencer;
  localparam int DEB = 4;
  localparam int TMO = 16;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;
  logic busy_r   = 1'b0;

  calc_key_if bus();
  assign bus.calc_busy = busy_r;

  calc_key_sequencer #(.DEBOUNCE_CYCLES(DEB), .BUSY_TIMEOUT(TMO)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .bus(bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // strobe index: 0 clear, 1 result, 2 add, 3 sub, 4 mult, 5 div
  logic [5:0] strobes;
  assign strobes = {bus.op_div, bus.op_mult, bus.op_sub, bus.op_add, bus.op_result, bus.op_clear};

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int cnt[6];
  int last_cyc[6];
  int busy_len = 0, busy_rem = 0, busy_fall_cyc = 0;
  bit bad_strobe = 1'b0;

  // Strobe recorder and datapath model: busy high for busy_len cycles after a strobe.
  always @(negedge CLOCK_50) begin
    if (strobes != 6'd0) begin
      if (!$onehot(strobes) || bus.state_dbg != 3'd1) bad_strobe = 1'b1;
      for (int k = 0; k < 6; k++)
        if (strobes[k]) begin cnt[k]++; last_cyc[k] = cyc; end
    end
    if (strobes != 6'd0 && busy_len > 0) begin
      busy_r   = 1'b1;
      busy_rem = busy_len;
    end else if (busy_rem > 0) begin
      busy_rem--;
      if (busy_rem == 0) begin busy_r = 1'b0; busy_fall_cyc = cyc; end
    end
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  function automatic int tot();
    int s = 0;
    for (int k = 0; k < 6; k++) s += cnt[k];
    return s;
  endfunction

  task automatic wait_op(input int idx, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (strobes[idx]) seen = 1'b1;
    end
  endtask

  task automatic set_mode(input logic m);
    bus.mode_sw = m;
    tick(10);
  endtask

  task automatic release_all();
    bus.KEY = 4'hF;
    tick(12);
  endtask

  typedef struct {
    logic mode;
    int   key;
    int   exp_op;   // -1: no strobe expected
  } vec_t;

  vec_t tbl[8];
  int   c0[6];
  int   t0, rise;
  bit   seen;

  initial begin
    tbl[0] = '{1'b0, 3, 2};
    tbl[1] = '{1'b0, 2, 3};
    tbl[2] = '{1'b0, 1, 4};
    tbl[3] = '{1'b0, 0, 5};
    tbl[4] = '{1'b1, 0, 0};
    tbl[5] = '{1'b1, 3, 1};
    tbl[6] = '{1'b1, 1, -1};
    tbl[7] = '{1'b1, 2, -1};
    for (int k = 0; k < 6; k++) begin cnt[k] = 0; last_cyc[k] = 0; end

    bus.KEY = 4'hF;
    bus.mode_sw = 1'b0;
    tick(3);
    check("rst_state", int'(bus.state_dbg), 0);
    check("rst_strobes", int'(strobes), 0);
    check("rst_flags", int'({bus.dropped, bus.timeout_err}), 0);
    RESET_N = 1'b1;
    tick(5);

    // held key -> exactly one single-cycle add
    t0 = tot(); c0 = cnt;
    bus.KEY[3] = 1'b0;
    tick(10);
    release_all();
    check("t1_add_cycles", cnt[2] - c0[2], 1);
    check("t1_total", tot() - t0, 1);

    // bouncing key never stable for DEB samples
    t0 = tot();
    for (int i = 0; i < 10; i++) begin bus.KEY[2] = i[0]; tick(2); end
    release_all();
    check("t2_bounce_total", tot() - t0, 0);

    for (int i = 0; i < 8; i++) begin
      set_mode(tbl[i].mode);
      t0 = tot(); c0 = cnt;
      bus.KEY[tbl[i].key] = 1'b0;
      tick(10);
      release_all();
      check($sformatf("vec%0d_total", i), tot() - t0, (tbl[i].exp_op >= 0) ? 1 : 0);
      if (tbl[i].exp_op >= 0)
        check($sformatf("vec%0d_op", i), cnt[tbl[i].exp_op] - c0[tbl[i].exp_op], 1);
      check($sformatf("vec%0d_dropped", i), int'(bus.dropped), 0);
    end
    set_mode(1'b0);

    // mult with 8 busy cycles; add queued during busy issues 2 cycles after busy falls
    c0 = cnt; busy_len = 8;
    bus.KEY[1] = 1'b0;
    wait_op(4, seen);
    check("t3_mult_seen", int'(seen), 1);
    bus.KEY[3] = 1'b0; bus.KEY[1] = 1'b1;
    tick(); busy_len = 0;
    tick(20);
    release_all();
    check("t3_add_count", cnt[2] - c0[2], 1);
    check("t3_add_after_busy", last_cyc[2] - busy_fall_cyc, 2);
    check("t3_dropped", int'(bus.dropped), 0);

    // second press while pending full is discarded
    c0 = cnt; busy_len = 8;
    bus.KEY[1] = 1'b0;
    wait_op(4, seen);
    check("t4_mult_seen", int'(seen), 1);
    bus.KEY[3] = 1'b0; bus.KEY[1] = 1'b1;
    tick(); busy_len = 0;
    bus.KEY[2] = 1'b0;
    tick(20);
    release_all();
    check("t4_add_count", cnt[2] - c0[2], 1);
    check("t4_sub_count", cnt[3] - c0[3], 0);
    check("t4_dropped", int'(bus.dropped), 1);

    // busy stuck high: error raised when the counter, zeroed on ACK entry, hits TMO
    busy_len = 20;
    bus.KEY[0] = 1'b0;
    wait_op(5, seen);
    check("t5_div_seen", int'(seen), 1);
    tick(); busy_len = 0; bus.KEY[0] = 1'b1;
    rise = -1;
    for (int i = 0; i < 30 && rise < 0; i++) begin
      if (bus.timeout_err) rise = cyc;
      else tick();
    end
    check("t5_timeout_cycle", rise - last_cyc[5], TMO + 1);
    check("t5_state_idle", int'(bus.state_dbg), 0);
    tick(12);
    check("t5_timeout_sticky", int'(bus.timeout_err), 1);

    // clear during WAIT_DONE with add pending
    c0 = cnt; busy_len = 14;
    bus.KEY[1] = 1'b0;
    wait_op(4, seen);
    check("t6_mult_seen", int'(seen), 1);
    bus.KEY[3] = 1'b0; bus.KEY[1] = 1'b1;
    tick(); busy_len = 0;
    tick(6);
    bus.mode_sw = 1'b1; bus.KEY[0] = 1'b0;
    tick(20);
    release_all();
    check("t6_clear_count", cnt[0] - c0[0], 1);
    check("t6_add_count", cnt[2] - c0[2], 0);
    check("t6_dropped", int'(bus.dropped), 0);
    check("t6_timeout", int'(bus.timeout_err), 0);
    set_mode(1'b0);

    // simultaneous KEY0+KEY3: KEY0 (div) wins, add discarded
    c0 = cnt;
    bus.KEY = 4'b0110;
    tick(10);
    release_all();
    check("sim_div_count", cnt[5] - c0[5], 1);
    check("sim_add_count", cnt[2] - c0[2], 0);
    check("sim_dropped", int'(bus.dropped), 1);

    // reset mid-op drops the pending add
    c0 = cnt; busy_len = 10;
    bus.KEY[1] = 1'b0;
    wait_op(4, seen);
    check("rst2_mult_seen", int'(seen), 1);
    bus.KEY[3] = 1'b0; bus.KEY[1] = 1'b1;
    tick(); busy_len = 0;
    tick(7);
    RESET_N = 1'b0; bus.KEY = 4'hF;
    #2;
    check("rst2_state", int'(bus.state_dbg), 0);
    check("rst2_dropped", int'(bus.dropped), 0);
    check("rst2_strobes", int'(strobes), 0);
    tick(2);
    RESET_N = 1'b1;
    tick(20);
    check("rst2_add_count", cnt[2] - c0[2], 0);

    check("strobe_onehot_in_issue", int'(bad_strobe), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
